// File: rtl/tetris_pkg.sv
// Shared types and board defaults for the piece mover datapath.
package tetris_pkg;

  typedef enum logic [1:0] {
    MV_LEFT  = 2'b00,
    MV_RIGHT = 2'b01,
    MV_DOWN  = 2'b10,
    MV_NONE  = 2'b11
  } move_dir_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    CHECK,
    FINISH
  } mover_state_t;

  localparam int BOARD_COLS = 8;
  localparam int BOARD_ROWS = 8;

endpackage

// File: rtl/adder.sv
// Plain unsigned adder, result truncated to WIDTH.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o
);

  assign sum_o = a_i + b_i;

endmodule

// File: rtl/cell_coord_gen.sv
// Absolute cell coordinates (base + offset) with a per-cell in-bounds flag.
// Sums are formed one bit wider so that x >= COLS / y >= ROWS is visible.
module cell_coord_gen #(
  parameter int XSIZE  = 3,
  parameter int YSIZE  = 3,
  parameter int NCELLS = 4,
  parameter int COLS   = 8,
  parameter int ROWS   = 8
) (
  input  logic [XSIZE-1:0]             base_x_i,
  input  logic [YSIZE-1:0]             base_y_i,
  input  logic [NCELLS-1:0][XSIZE-1:0] off_x_i,
  input  logic [NCELLS-1:0][YSIZE-1:0] off_y_i,
  output logic [NCELLS-1:0][XSIZE-1:0] cell_x_o,
  output logic [NCELLS-1:0][YSIZE-1:0] cell_y_o,
  output logic [NCELLS-1:0]            in_bnd_o
);

  for (genvar i = 0; i < NCELLS; i++) begin : g_cell
    logic [XSIZE:0] sum_x;
    logic [YSIZE:0] sum_y;

    adder #(.WIDTH(XSIZE+1)) u_add_x (
      .a_i  ({1'b0, base_x_i}),
      .b_i  ({1'b0, off_x_i[i]}),
      .sum_o(sum_x)
    );

    adder #(.WIDTH(YSIZE+1)) u_add_y (
      .a_i  ({1'b0, base_y_i}),
      .b_i  ({1'b0, off_y_i[i]}),
      .sum_o(sum_y)
    );

    assign cell_x_o[i] = sum_x[XSIZE-1:0];
    assign cell_y_o[i] = sum_y[YSIZE-1:0];
    assign in_bnd_o[i] = (sum_x < (XSIZE+1)'(COLS)) && (sum_y < (YSIZE+1)'(ROWS));
  end

endmodule

// File: rtl/piece_mover.sv
// Active-piece mover: latches spawn/move requests, bounds-checks the
// candidate cells, serially probes the occupancy RAM, then commits or rejects.
module piece_mover
  import tetris_pkg::*;
#(
  parameter int XSIZE  = 3,
  parameter int YSIZE  = 3,
  parameter int NCELLS = 4,
  parameter int COLS   = BOARD_COLS,
  parameter int ROWS   = BOARD_ROWS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        spawn_valid,
  input  logic [NCELLS-1:0][XSIZE-1:0] spawn_offX,
  input  logic [NCELLS-1:0][YSIZE-1:0] spawn_offY,
  input  logic [XSIZE-1:0]            spawn_bX,
  input  logic [YSIZE-1:0]            spawn_bY,
  input  logic                        move_valid,
  input  logic [1:0]                  move_dir,
  output logic                        occ_rd_en,
  output logic [XSIZE-1:0]            occ_rd_x,
  output logic [YSIZE-1:0]            occ_rd_y,
  input  logic                        occ_rd_data,
  output logic                        busy,
  output logic                        done,
  output logic                        accepted,
  output logic                        lock,
  output logic                        game_over,
  output logic [NCELLS-1:0][XSIZE-1:0] cellX,
  output logic [NCELLS-1:0][YSIZE-1:0] cellY
);

  localparam int IW = $clog2(NCELLS + 1);

  mover_state_t                 state_q, state_d;
  logic [XSIZE-1:0]             base_x_q, cand_bx_q, cand_bx_d;
  logic [YSIZE-1:0]             base_y_q, cand_by_q, cand_by_d;
  logic [NCELLS-1:0][XSIZE-1:0] off_x_q, cand_ox_q, cand_ox_d, cellx_q, cell_x;
  logic [NCELLS-1:0][YSIZE-1:0] off_y_q, cand_oy_q, cand_oy_d, celly_q, cell_y;
  logic [NCELLS-1:0]            in_bnd;
  logic                         cand_wrap_q, cand_wrap_d;
  logic                         is_spawn_q, is_spawn_d, is_down_q, is_down_d;
  logic [IW-1:0]                idx_q, idx_d;
  logic                         hit_q, hit_d, final_hit;
  logic                         done_q, done_d, acc_q, acc_d, lock_q, lock_d;
  logic                         go_q, go_d, commit;
  logic [XSIZE:0]               mv_x;
  logic [YSIZE:0]               mv_y;
  move_dir_t                    dir;

  assign dir = move_dir_t'(move_dir);

  cell_coord_gen #(
    .XSIZE(XSIZE), .YSIZE(YSIZE), .NCELLS(NCELLS), .COLS(COLS), .ROWS(ROWS)
  ) u_coord (
    .base_x_i(cand_bx_q),
    .base_y_i(cand_by_q),
    .off_x_i (cand_ox_q),
    .off_y_i (cand_oy_q),
    .cell_x_o(cell_x),
    .cell_y_o(cell_y),
    .in_bnd_o(in_bnd)
  );

  // Moved base at one extra bit; the top bit flags a wrap past either edge.
  always_comb begin
    mv_x = {1'b0, base_x_q};
    mv_y = {1'b0, base_y_q};
    case (dir)
      MV_LEFT:  mv_x = {1'b0, base_x_q} - (XSIZE+1)'(1);
      MV_RIGHT: mv_x = {1'b0, base_x_q} + (XSIZE+1)'(1);
      MV_DOWN:  mv_y = {1'b0, base_y_q} + (YSIZE+1)'(1);
      default:  ;
    endcase
  end

  // Read port: one cell per CHECK cycle, address held at 0 when idle.
  assign occ_rd_en = (state_q == CHECK) && (idx_q < IW'(NCELLS));
  always_comb begin
    occ_rd_x = '0;
    occ_rd_y = '0;
    for (int i = 0; i < NCELLS; i++) begin
      if (occ_rd_en && idx_q == IW'(i)) begin
        occ_rd_x = cell_x[i];
        occ_rd_y = cell_y[i];
      end
    end
  end

  // Next-state, request intake and FINISH outcome.
  always_comb begin
    state_d     = state_q;
    cand_bx_d   = cand_bx_q;
    cand_by_d   = cand_by_q;
    cand_ox_d   = cand_ox_q;
    cand_oy_d   = cand_oy_q;
    cand_wrap_d = cand_wrap_q;
    is_spawn_d  = is_spawn_q;
    is_down_d   = is_down_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    done_d      = 1'b0;
    acc_d       = 1'b0;
    lock_d      = 1'b0;
    go_d        = go_q;
    commit      = 1'b0;
    final_hit   = hit_q | occ_rd_data;
    case (state_q)
      // FINISH behaves like IDLE for intake so back-to-back requests are taken.
      IDLE, FINISH: begin
        state_d = IDLE;
        if (spawn_valid) begin
          cand_bx_d   = spawn_bX;
          cand_by_d   = spawn_bY;
          cand_ox_d   = spawn_offX;
          cand_oy_d   = spawn_offY;
          cand_wrap_d = 1'b0;
          is_spawn_d  = 1'b1;
          is_down_d   = 1'b0;
          state_d     = CALC;
        end else if (move_valid && !go_q && dir != MV_NONE) begin
          cand_bx_d   = mv_x[XSIZE-1:0];
          cand_by_d   = mv_y[YSIZE-1:0];
          cand_ox_d   = off_x_q;
          cand_oy_d   = off_y_q;
          cand_wrap_d = mv_x[XSIZE] | mv_y[YSIZE];
          is_spawn_d  = 1'b0;
          is_down_d   = (dir == MV_DOWN);
          state_d     = CALC;
        end
      end
      CALC: begin
        if (cand_wrap_q || !(&in_bnd)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          lock_d  = is_down_q;
          go_d    = go_q | is_spawn_q;
        end else begin
          state_d = CHECK;
          idx_d   = '0;
          hit_d   = 1'b0;
        end
      end
      CHECK: begin
        // Data for read idx-1 arrives while idx is on screen; idx 0 has none.
        if (idx_q != '0) hit_d = final_hit;
        if (idx_q == IW'(NCELLS)) begin
          state_d = FINISH;
          done_d  = 1'b1;
          acc_d   = !final_hit;
          lock_d  = final_hit & is_down_q;
          go_d    = go_q | (final_hit & is_spawn_q);
          commit  = !final_hit;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, candidate latches, committed piece and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_x_q    <= '0;
      base_y_q    <= '0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      cand_bx_q   <= '0;
      cand_by_q   <= '0;
      cand_ox_q   <= '0;
      cand_oy_q   <= '0;
      cand_wrap_q <= 1'b0;
      is_spawn_q  <= 1'b0;
      is_down_q   <= 1'b0;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      done_q      <= 1'b0;
      acc_q       <= 1'b0;
      lock_q      <= 1'b0;
      go_q        <= 1'b0;
      cellx_q     <= '0;
      celly_q     <= '0;
    end else begin
      state_q     <= state_d;
      cand_bx_q   <= cand_bx_d;
      cand_by_q   <= cand_by_d;
      cand_ox_q   <= cand_ox_d;
      cand_oy_q   <= cand_oy_d;
      cand_wrap_q <= cand_wrap_d;
      is_spawn_q  <= is_spawn_d;
      is_down_q   <= is_down_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      done_q      <= done_d;
      acc_q       <= acc_d;
      lock_q      <= lock_d;
      go_q        <= go_d;
      if (commit) begin
        base_x_q <= cand_bx_q;
        base_y_q <= cand_by_q;
        off_x_q  <= cand_ox_q;
        off_y_q  <= cand_oy_q;
        cellx_q  <= cell_x;
        celly_q  <= cell_y;
      end
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign accepted  = acc_q;
  assign lock      = lock_q;
  assign game_over = go_q;
  assign cellX     = cellx_q;
  assign cellY     = celly_q;

endmodule

// File: tb/tb_piece_mover.sv
// Directed bench for piece_mover: table of requests plus corner sequences.
module tb_piece_mover;
  import tetris_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             spawn_valid = 1'b0, move_valid = 1'b0;
  logic [3:0][2:0]  spawn_offX = '0, spawn_offY = '0;
  logic [2:0]       spawn_bX = '0, spawn_bY = '0;
  logic [1:0]       move_dir = '0;
  logic             occ_rd_en, occ_rd_data = 1'b0;
  logic [2:0]       occ_rd_x, occ_rd_y;
  logic             busy, done, accepted, lock, game_over;
  logic [3:0][2:0]  cellX, cellY;
  logic [7:0][7:0]  board = '0;

  int cyc = 0;
  int n_cmp = 0, n_err = 0;
  int req_k = 0;

  typedef struct { int c; int x; int y; } rd_t;
  rd_t rd_q[$];

  piece_mover dut (
    .clk(clk), .rst_n(rst_n),
    .spawn_valid(spawn_valid), .spawn_offX(spawn_offX), .spawn_offY(spawn_offY),
    .spawn_bX(spawn_bX), .spawn_bY(spawn_bY),
    .move_valid(move_valid), .move_dir(move_dir),
    .occ_rd_en(occ_rd_en), .occ_rd_x(occ_rd_x), .occ_rd_y(occ_rd_y),
    .occ_rd_data(occ_rd_data),
    .busy(busy), .done(done), .accepted(accepted), .lock(lock),
    .game_over(game_over), .cellX(cellX), .cellY(cellY)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous occupancy RAM model.
  always @(posedge clk) if (occ_rd_en) occ_rd_data <= board[occ_rd_y][occ_rd_x];

  // Read log in spec cycle numbering (cycle n ends at edge n).
  always @(negedge clk) if (rst_n && occ_rd_en) rd_q.push_back('{cyc + 1, int'(occ_rd_x), int'(occ_rd_y)});

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0][2:0] pk(input int a0, input int a1, input int a2, input int a3);
    logic [3:0][2:0] r;
    r[0] = 3'(a0); r[1] = 3'(a1); r[2] = 3'(a2); r[3] = 3'(a3);
    return r;
  endfunction

  // Drive one request for one edge, then wait (bounded) for done.
  task automatic do_req(input bit sp, input bit mv, input logic [1:0] dir,
                        input logic [2:0] bx, input logic [2:0] by, input bit pulse,
                        output int lat, output bit acc, output bit lck);
    rd_q.delete();
    @(posedge clk); #1;
    spawn_valid = sp; move_valid = mv; move_dir = dir;
    spawn_offX = pk(0, 1, 0, 1); spawn_offY = pk(0, 0, 1, 1);
    spawn_bX = bx; spawn_bY = by;
    req_k = cyc + 1;
    @(posedge clk); #1;
    spawn_valid = 1'b0; move_valid = 1'b0;
    lat = -1; acc = 1'b0; lck = 1'b0;
    for (int t = 0; t < 20 && lat < 0; t++) begin
      @(negedge clk);
      if (pulse && t == 2) begin move_valid = 1'b1; move_dir = 2'b01; end
      if (pulse && t == 3) move_valid = 1'b0;
      if (done) begin lat = cyc + 1 - req_k; acc = accepted; lck = lock; end
    end
  endtask

  typedef struct {
    bit sp; logic [1:0] dir; logic [2:0] bx, by;
    bit occ_v; int occx, occy;
    int lat; bit acc, lck, go;
    logic [3:0][2:0] ecx, ecy;
  } vec_t;

  vec_t v[17];

  initial begin
    int lat, nd;
    bit acc, lck;

    v[0]  = '{1'b1, 2'd0, 3'd3, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(0,0,1,1)};
    v[1]  = '{1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(2,3,2,3), pk(0,0,1,1)};
    v[2]  = '{1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(1,2,1,2), pk(0,0,1,1)};
    v[3]  = '{1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(0,1,0,1), pk(0,0,1,1)};
    v[4]  = '{1'b0, 2'd0, 3'd0, 3'd0, 1'b0, 0, 0, 2, 1'b0, 1'b0, 1'b0, pk(0,1,0,1), pk(0,0,1,1)};
    v[5]  = '{1'b1, 2'd0, 3'd6, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(6,7,6,7), pk(0,0,1,1)};
    v[6]  = '{1'b0, 2'd1, 3'd0, 3'd0, 1'b0, 0, 0, 2, 1'b0, 1'b0, 1'b0, pk(6,7,6,7), pk(0,0,1,1)};
    v[7]  = '{1'b1, 2'd0, 3'd3, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(0,0,1,1)};
    v[8]  = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b1, 4, 2, 7, 1'b0, 1'b1, 1'b0, pk(3,4,3,4), pk(0,0,1,1)};
    v[9]  = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(1,1,2,2)};
    v[10] = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(2,2,3,3)};
    v[11] = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(3,3,4,4)};
    v[12] = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(4,4,5,5)};
    v[13] = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(5,5,6,6)};
    v[14] = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 7, 1'b1, 1'b0, 1'b0, pk(3,4,3,4), pk(6,6,7,7)};
    v[15] = '{1'b0, 2'd2, 3'd0, 3'd0, 1'b0, 0, 0, 2, 1'b0, 1'b1, 1'b0, pk(3,4,3,4), pk(6,6,7,7)};
    v[16] = '{1'b1, 2'd0, 3'd3, 3'd0, 1'b1, 3, 0, 7, 1'b0, 1'b0, 1'b1, pk(3,4,3,4), pk(6,6,7,7)};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_acc", accepted, 0);
    chk("rst_lock", lock, 0);
    chk("rst_go", game_over, 0);
    chk("rst_rden", occ_rd_en, 0);
    chk("rst_rdxy", {occ_rd_x, occ_rd_y}, 0);
    chk("rst_cells", {cellX, cellY}, 0);
    rst_n = 1'b1;

    foreach (v[i]) begin
      board = '0;
      if (v[i].occ_v) board[v[i].occy][v[i].occx] = 1'b1;
      do_req(v[i].sp, !v[i].sp, v[i].dir, v[i].bx, v[i].by, 1'b0, lat, acc, lck);
      chk($sformatf("v%0d_lat", i), lat, v[i].lat);
      chk($sformatf("v%0d_acc", i), acc, v[i].acc);
      chk($sformatf("v%0d_lock", i), lck, v[i].lck);
      chk($sformatf("v%0d_go", i), game_over, v[i].go);
      chk($sformatf("v%0d_cellX", i), cellX, v[i].ecx);
      chk($sformatf("v%0d_cellY", i), cellY, v[i].ecy);
      chk($sformatf("v%0d_nreads", i), rd_q.size(), (v[i].lat == 7) ? 4 : 0);
      if (i == 0 && rd_q.size() == 4) begin
        chk("v0_rd0", rd_q[0].x * 8 + rd_q[0].y, 3 * 8 + 0);
        chk("v0_rd1", rd_q[1].x * 8 + rd_q[1].y, 4 * 8 + 0);
        chk("v0_rd2", rd_q[2].x * 8 + rd_q[2].y, 3 * 8 + 1);
        chk("v0_rd3", rd_q[3].x * 8 + rd_q[3].y, 4 * 8 + 1);
        chk("v0_rd_first_cyc", rd_q[0].c, req_k + 2);
        chk("v0_rd_last_cyc", rd_q[3].c, req_k + 5);
      end
      @(negedge clk);
      chk($sformatf("v%0d_done_pulse", i), done, 0);
      chk($sformatf("v%0d_acc_after", i), accepted | lock, 0);
      chk($sformatf("v%0d_idle_after", i), busy, 0);
    end

    // Game over: moves are ignored, spawns still run.
    board = '0;
    do_req(1'b0, 1'b1, 2'd0, 3'd0, 3'd0, 1'b0, lat, acc, lck);
    chk("go_move_ignored", lat, -1);
    do_req(1'b1, 1'b0, 2'd0, 3'd2, 3'd0, 1'b0, lat, acc, lck);
    chk("go_spawn_lat", lat, 7);
    chk("go_spawn_acc", acc, 1);
    chk("go_spawn_cellX", cellX, pk(2,3,2,3));
    chk("go_still_set", game_over, 1);

    // Reset in the middle of CHECK.
    @(posedge clk); #1;
    spawn_valid = 1'b1; spawn_bX = 3'd3; spawn_bY = 3'd0;
    req_k = cyc + 1;
    @(posedge clk); #1;
    spawn_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("midrst_pre_rden", occ_rd_en, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_rden", occ_rd_en, 0);
    chk("midrst_done", done, 0);
    chk("midrst_cells", {cellX, cellY}, 0);
    chk("midrst_go", game_over, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Spawn + move together: spawn wins; a move pulse while busy is dropped.
    do_req(1'b1, 1'b1, 2'd2, 3'd3, 3'd0, 1'b1, lat, acc, lck);
    chk("both_lat", lat, 7);
    chk("both_acc", acc, 1);
    chk("both_cellX", cellX, pk(3,4,3,4));
    chk("both_cellY", cellY, pk(0,0,1,1));
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("busy_pulse_ignored", nd, 0);
    chk("busy_pulse_cellX", cellX, pk(3,4,3,4));

    // Reserved move code: nothing happens.
    do_req(1'b0, 1'b1, 2'd3, 3'd0, 3'd0, 1'b0, lat, acc, lck);
    chk("dir11_nodone", lat, -1);
    chk("dir11_cells", {cellX, cellY}, {pk(3,4,3,4), pk(0,0,1,1)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
